// File: rtl/mult_div_unit.sv
// mult_div_unit: MIPS-style HI/LO multiply/divide unit.
//
// Purpose:
//   Runs mult/multu in 5 cycles and div/divu in 10 cycles. Results land in
//   the HI and LO registers on the same edge that busy falls. mthi/mtlo
//   writes go through mdwe/hilo/wdata while the unit is idle.
//
// Configuration:
//   MULT_DIV_UNIT_DIV_EN - when defined, the divide path and the DIV state
//                          are built. When undefined, divide starts are
//                          ignored and only multiply and mthi/mtlo remain.
//
// Ports:
//   clk    in   1  clock, all state changes on its rising edge
//   reset  in   1  synchronous active-high reset
//   start  in   1  launch the operation selected by mdop
//   mdop   in   2  bit1 = divide/multiply, bit0 = signed/unsigned
//   mdwe   in   1  mthi/mtlo write strobe (idle only)
//   hilo   in   1  mdwe target, 1 = HI, 0 = LO
//   a, b   in  32  rs / rt operands
//   wdata  in  32  mthi/mtlo data
//   busy   out  1  high while an operation is in flight (registered)
//   hi, lo out 32  current HI / LO register values
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  mdop,
  input  logic        mdwe,
  input  logic        hilo,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1
`ifdef MULT_DIV_UNIT_DIV_EN
    ,
    DIV  = 2'd2
`endif
  } state_t;

  // The counter is loaded with latency-1 so that busy stays high for
  // exactly the full latency after the start edge.
  localparam logic [3:0] MUL_LAST = 4'd4;
`ifdef MULT_DIV_UNIT_DIV_EN
  localparam logic [3:0] DIV_LAST = 4'd9;
`endif

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        busy_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        signed_q;

  // Multiply datapath on the latched operands. Sign- or zero-extending both
  // operands to 64 bits lets one unsigned multiplier serve mult and multu,
  // since the low 64 bits of the product are the same either way.
  logic [63:0] extA;
  logic [63:0] extB;
  logic [63:0] product;

  always_comb begin
    extA    = signed_q ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    extB    = signed_q ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    product = extA * extB;
  end

`ifdef MULT_DIV_UNIT_DIV_EN
  // Divide datapath on magnitudes, signs reapplied afterwards. Working on
  // magnitudes makes 0x80000000 / -1 fall out naturally as 0x80000000 with
  // remainder 0 instead of hitting the signed overflow case.
  logic        aNeg;
  logic        bNeg;
  logic [31:0] aMag;
  logic [31:0] bMag;
  logic [31:0] quoMag;
  logic [31:0] remMag;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        divByZero;

  always_comb begin
    aNeg      = signed_q & a_q[31];
    bNeg      = signed_q & b_q[31];
    aMag      = aNeg ? (32'd0 - a_q) : a_q;
    bMag      = bNeg ? (32'd0 - b_q) : b_q;
    divByZero = (b_q == 32'd0);
    quoMag    = divByZero ? 32'd0 : (aMag / bMag);
    remMag    = divByZero ? 32'd0 : (aMag % bMag);
    quo       = (aNeg ^ bNeg) ? (32'd0 - quoMag) : quoMag;
    rem       = aNeg ? (32'd0 - remMag) : remMag;
  end
`endif

  // Control FSM. Only the idle state looks at start/mdwe, which is what
  // makes start and mdwe ignored while busy; operands are latched at the
  // start edge so later input changes cannot disturb an operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      busy_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      signed_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !mdop[1]) begin
            a_q      <= a;
            b_q      <= b;
            signed_q <= mdop[0];
            cnt_q    <= MUL_LAST;
            busy_q   <= 1'b1;
            state_q  <= MUL;
`ifdef MULT_DIV_UNIT_DIV_EN
          end else if (start && mdop[1]) begin
            a_q      <= a;
            b_q      <= b;
            signed_q <= mdop[0];
            cnt_q    <= DIV_LAST;
            busy_q   <= 1'b1;
            state_q  <= DIV;
`endif
          end else if (mdwe) begin
            if (hilo) begin
              hi_q <= wdata;
            end else begin
              lo_q <= wdata;
            end
          end
        end

        MUL: begin
          if (cnt_q == 4'd0) begin
            hi_q    <= product[63:32];
            lo_q    <= product[31:0];
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end

`ifdef MULT_DIV_UNIT_DIV_EN
        DIV: begin
          if (cnt_q == 4'd0) begin
            // Divide by zero still spends the full latency but leaves HI/LO alone.
            if (!divByZero) begin
              hi_q <= rem;
              lo_q <= quo;
            end
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
`endif

        default: begin
          cnt_q   <= 4'd0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
